oam_scanner: RTL and testbench

Parametrised OAM scan and sprite-fetch sequencer for the GB/GBC PPU. Sits between OAM RAM and the pixel fetcher. During mode 2 it selects up to a runtime-limited number of objects on the current line. During mode 3 it sequences tile and attribute reads for the selected object whose X matches `h_cnt`. It extends the fixed 10-per-line scanner with:
- a configurable slot depth;
- a run-time per-line limit, used for the flicker-reduction option;
- an overflow flag;
- an explicit fetch handshake.

---
 rtl/oam_scanner_pkg.sv | 27 ++
 rtl/oam_slot_match.sv | 24 ++
 rtl/oam_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_oam_scanner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_scanner_pkg.sv
// Shared state encodings, OAM layout constants and helpers for the OAM scanner.
package oam_scanner_pkg;

    localparam logic [1:0] EV_IDLE = 2'd0;
    localparam logic [1:0] EV_Y    = 2'd1;
    localparam logic [1:0] EV_X    = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_TILE  = 2'd1;
    localparam logic [1:0] F_ATTR  = 2'd2;
    localparam logic [1:0] F_VALID = 2'd3;

    localparam logic [7:0] X_INVALID = 8'hFF;

    localparam logic [1:0] OFF_Y    = 2'd0;
    localparam logic [1:0] OFF_X    = 2'd1;
    localparam logic [1:0] OFF_TILE = 2'd2;
    localparam logic [1:0] OFF_ATTR = 2'd3;

    localparam int ROW_W = 4;

    function automatic logic [ROW_W-1:0] flip_row(input logic [ROW_W-1:0] row4, input logic yflip);
        return yflip ? ~row4 : row4;
    endfunction

endpackage

// File: rtl/oam_slot_match.sv
// X-compare across all sprite slots with a lowest-index-wins priority encoder.
module oam_slot_match #(
    parameter int MAX_SLOTS = 16
) (
    input  logic [7:0] slot_x [MAX_SLOTS],
    input  logic [7:0] h_cnt,
    output logic       any_match,
    output logic [3:0] slot
);
    import oam_scanner_pkg::*;

    // Scanning downward lets the lowest matching slot overwrite the others.
    always_comb begin
        any_match = 1'b0;
        slot      = '0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (slot_x[i] == h_cnt && slot_x[i] != X_INVALID) begin
                any_match = 1'b1;
                slot      = 4'(i);
            end
        end
    end

endmodule

// File: rtl/oam_scanner.sv
// OAM scan (mode 2) and sprite tile/attribute fetch sequencer (mode 3) for the PPU.
module oam_scanner #(
    parameter int NUM_OBJ   = 40,
    parameter int MAX_SLOTS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        lcd_on,
    input  logic        size16,
    input  logic [4:0]  obj_limit,
    input  logic [7:0]  v_cnt,
    input  logic [7:0]  h_cnt,
    input  logic        eval_start,
    output logic        eval_busy,
    output logic        eval_done,
    output logic        overflow,
    output logic [4:0]  obj_count,
    output logic [7:0]  oam_rd_addr,
    input  logic [7:0]  oam_rd_data,
    input  logic        fetch_en,
    output logic        fetch_req,
    output logic        fetch_valid,
    input  logic        fetch_done,
    output logic [3:0]  fetch_slot,
    output logic [7:0]  fetch_attr,
    output logic [10:0] sprite_addr
);
    import oam_scanner_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(NUM_OBJ - 1);
    localparam logic [4:0] SLOT_CAP = 5'(MAX_SLOTS);

    logic [1:0]       ev_state;
    logic [1:0]       f_state;
    logic [5:0]       idx;
    logic [7:0]       y_lat;
    logic [7:0]       slot_x   [MAX_SLOTS];
    logic [5:0]       slot_idx [MAX_SLOTS];
    logic [ROW_W-1:0] slot_row [MAX_SLOTS];

    logic             any_match;
    logic [3:0]       match_slot;
    logic [5:0]       sel_idx;
    logic [ROW_W-1:0] sel_row;

    logic [5:0]       f_obj;
    logic [7:0]       f_hpos;
    logic [ROW_W-1:0] f_row4;
    logic [7:0]       tile;
    logic [ROW_W-1:0] row;

    logic [4:0]       limit;
    logic [7:0]       dy;
    logic             on_line;
    logic             fetch_allowed;
    logic             f_abort;

    assign limit         = (obj_limit > SLOT_CAP) ? SLOT_CAP : obj_limit;
    // Wraparound subtraction: objects above the line or with Y=0 / Y>=160 land far above the height.
    assign dy            = v_cnt + 8'd16 - y_lat;
    assign on_line       = dy < (size16 ? 8'd16 : 8'd8);
    assign fetch_allowed = (ev_state == EV_IDLE) || (ev_state == EV_DONE);
    assign f_abort       = !fetch_en || (h_cnt != f_hpos);

    oam_slot_match #(
        .MAX_SLOTS (MAX_SLOTS)
    ) u_match (
        .slot_x    (slot_x),
        .h_cnt     (h_cnt),
        .any_match (any_match),
        .slot      (match_slot)
    );

    always_comb begin
        sel_idx = '0;
        sel_row = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (4'(i) == match_slot) begin
                sel_idx = slot_idx[i];
                sel_row = slot_row[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_state    <= EV_IDLE;
            f_state     <= F_IDLE;
            idx         <= '0;
            y_lat       <= '0;
            obj_count   <= '0;
            overflow    <= 1'b0;
            oam_rd_addr <= '0;
            f_obj       <= '0;
            f_hpos      <= '0;
            f_row4      <= '0;
            tile        <= '0;
            row         <= '0;
            fetch_slot  <= '0;
            fetch_attr  <= '0;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                slot_x[i]   <= X_INVALID;
                slot_idx[i] <= '0;
                slot_row[i] <= '0;
            end
        end else if (ce) begin
            if (!lcd_on) begin
                ev_state    <= EV_IDLE;
                f_state     <= F_IDLE;
                idx         <= '0;
                obj_count   <= '0;
                overflow    <= 1'b0;
                oam_rd_addr <= '0;
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    slot_x[i] <= X_INVALID;
                end
            end else if (eval_start) begin
                ev_state    <= EV_Y;
                f_state     <= F_IDLE;
                idx         <= '0;
                obj_count   <= '0;
                overflow    <= 1'b0;
                oam_rd_addr <= {6'd0, OFF_Y};
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    slot_x[i] <= X_INVALID;
                end
            end else begin
                case (ev_state)
                    EV_Y: begin
                        y_lat       <= oam_rd_data;
                        oam_rd_addr <= {idx, OFF_X};
                        ev_state    <= EV_X;
                    end
                    EV_X: begin
                        if (on_line) begin
                            if (obj_count < limit) begin
                                for (int i = 0; i < MAX_SLOTS; i++) begin
                                    if (5'(i) == obj_count) begin
                                        slot_x[i]   <= oam_rd_data;
                                        slot_idx[i] <= idx;
                                        slot_row[i] <= dy[ROW_W-1:0];
                                    end
                                end
                                obj_count <= obj_count + 5'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        oam_rd_addr <= {idx + 6'd1, OFF_Y};
                        idx         <= idx + 6'd1;
                        ev_state    <= (idx == LAST_IDX) ? EV_DONE : EV_Y;
                    end
                    default: ;
                endcase

                // The fetch port only owns the OAM address while no scan is running.
                if (fetch_allowed) begin
                    case (f_state)
                        F_IDLE: begin
                            if (fetch_en && any_match) begin
                                fetch_slot  <= match_slot;
                                f_obj       <= sel_idx;
                                f_row4      <= sel_row;
                                f_hpos      <= h_cnt;
                                oam_rd_addr <= {sel_idx, OFF_TILE};
                                f_state     <= F_TILE;
                            end
                        end
                        F_TILE: begin
                            if (f_abort) begin
                                f_state <= F_IDLE;
                            end else begin
                                tile        <= oam_rd_data;
                                oam_rd_addr <= {f_obj, OFF_ATTR};
                                f_state     <= F_ATTR;
                            end
                        end
                        F_ATTR: begin
                            if (f_abort) begin
                                f_state <= F_IDLE;
                            end else begin
                                fetch_attr <= oam_rd_data;
                                row        <= flip_row(f_row4, oam_rd_data[6]);
                                f_state    <= F_VALID;
                            end
                        end
                        default: begin
                            if (fetch_done) begin
                                for (int i = 0; i < MAX_SLOTS; i++) begin
                                    if (4'(i) == fetch_slot) begin
                                        slot_x[i] <= X_INVALID;
                                    end
                                end
                                f_state <= F_IDLE;
                            end
                        end
                    endcase
                end else begin
                    f_state <= F_IDLE;
                end
            end
        end
    end

    assign eval_busy   = (ev_state == EV_Y) || (ev_state == EV_X);
    assign eval_done   = (ev_state == EV_DONE);
    assign fetch_valid = (f_state == F_VALID);
    assign fetch_req   = any_match & fetch_en;
    assign sprite_addr = size16 ? {tile[7:1], row} : {tile, row[2:0]};

endmodule

// File: tb/tb_oam_scanner.sv
// Randomized and directed bench for oam_scanner against a line-selection reference model.
module tb_oam_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        lcd_on = 1'b1;
    logic        size16 = 1'b0;
    logic [4:0]  obj_limit = 5'd10;
    logic [7:0]  v_cnt = 8'd0;
    logic [7:0]  h_cnt = 8'd0;
    logic        eval_start = 1'b0;
    logic        eval_busy, eval_done, overflow;
    logic [4:0]  obj_count;
    logic [7:0]  oam_rd_addr;
    logic [7:0]  oam_rd_data;
    logic        fetch_en = 1'b0;
    logic        fetch_req, fetch_valid;
    logic        fetch_done = 1'b0;
    logic [3:0]  fetch_slot;
    logic [7:0]  fetch_attr;
    logic [10:0] sprite_addr;

    logic [7:0]  oam [256];
    int          sel [$];
    int          n_vec = 0;
    int          n_err = 0;

    assign oam_rd_data = oam[oam_rd_addr];

    always #5 clk = ~clk;

    oam_scanner #(
        .NUM_OBJ   (40),
        .MAX_SLOTS (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .lcd_on      (lcd_on),
        .size16      (size16),
        .obj_limit   (obj_limit),
        .v_cnt       (v_cnt),
        .h_cnt       (h_cnt),
        .eval_start  (eval_start),
        .eval_busy   (eval_busy),
        .eval_done   (eval_done),
        .overflow    (overflow),
        .obj_count   (obj_count),
        .oam_rd_addr (oam_rd_addr),
        .oam_rd_data (oam_rd_data),
        .fetch_en    (fetch_en),
        .fetch_req   (fetch_req),
        .fetch_valid (fetch_valid),
        .fetch_done  (fetch_done),
        .fetch_slot  (fetch_slot),
        .fetch_attr  (fetch_attr),
        .sprite_addr (sprite_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // One enabled PPU cycle, preceded by a random number of stalled clocks.
    task automatic step();
        int n;
        n = $urandom_range(0, 1);
        for (int k = 0; k < n; k++) begin
            ce = 1'b0;
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic clear_oam();
        for (int a = 0; a < 256; a++) oam[a] = 8'd0;
    endtask

    // Reference: walk OAM in order and keep the first `limit` objects that cover the line.
    task automatic model_scan(output int cnt, output bit ovf);
        int lim, d, h;
        lim = (int'(obj_limit) > 16) ? 16 : int'(obj_limit);
        h = size16 ? 16 : 8;
        sel.delete();
        ovf = 1'b0;
        for (int o = 0; o < 40; o++) begin
            d = (int'(v_cnt) + 16 - int'(oam[4*o])) & 255;
            if (d < h) begin
                if (sel.size() < lim) sel.push_back(o);
                else ovf = 1'b1;
            end
        end
        cnt = sel.size();
    endtask

    task automatic run_scan();
        int n, cnt;
        bit ovf;
        eval_start = 1'b1;
        step();
        eval_start = 1'b0;
        chk("busy_start", eval_busy, 1);
        n = 0;
        while (!eval_done && n < 400) begin
            step();
            n++;
        end
        chk("scan_len", n, 80);
        chk("busy_end", eval_busy, 0);
        model_scan(cnt, ovf);
        chk("obj_count", obj_count, cnt);
        chk("overflow", overflow, ovf);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!fetch_valid && n < 12) begin
            step();
            n++;
        end
    endtask

    // Serve every selected object sitting at X == h, in OAM order, then expect no request.
    task automatic drain(input int h);
        int n, o, row4, row, exp_addr;
        logic [7:0] attr, tile;
        h_cnt = 8'(h);
        fetch_en = 1'b1;
        #1;
        for (int k = 0; k < sel.size(); k++) begin
            o = sel[k];
            if (int'(oam[4*o+1]) != h) continue;
            chk("fetch_req", fetch_req, 1);
            wait_valid(n);
            chk("fetch_lat", n, 3);
            tile = oam[4*o+2];
            attr = oam[4*o+3];
            row4 = (int'(v_cnt) + 16 - int'(oam[4*o])) & 15;
            row = attr[6] ? (~row4 & 15) : row4;
            exp_addr = size16 ? ((int'(tile) >> 1) << 4) | row : (int'(tile) << 3) | (row & 7);
            chk("fetch_slot", fetch_slot, k);
            chk("fetch_attr", fetch_attr, attr);
            chk("sprite_addr", sprite_addr, exp_addr);
            fetch_done = 1'b1;
            step();
            fetch_done = 1'b0;
            chk("valid_drop", fetch_valid, 0);
        end
        chk("req_drained", fetch_req, 0);
        fetch_en = 1'b0;
    endtask

    task automatic setup_row_of_twelve();
        clear_oam();
        for (int i = 0; i < 12; i++) begin
            oam[4*i]   = 8'd16;
            oam[4*i+1] = 8'(8 + 8*i);
            oam[4*i+2] = 8'(i);
        end
        v_cnt = 8'd0;
        size16 = 1'b0;
    endtask

    initial begin
        int n, cnt, hsel;
        bit ovf;
        clear_oam();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", eval_busy, 0);
        chk("rst_done", eval_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", obj_count, 0);
        chk("rst_addr", oam_rd_addr, 0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_req", fetch_req, 0);
        chk("rst_saddr", sprite_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Twelve objects on line 0, limit 10 then 16
        setup_row_of_twelve();
        obj_limit = 5'd10;
        run_scan();
        chk("A_count", obj_count, 10);
        chk("A_ovf", overflow, 1);
        obj_limit = 5'd16;
        run_scan();
        chk("B_count", obj_count, 12);
        chk("B_ovf", overflow, 0);
        obj_limit = 5'd0;
        run_scan();
        chk("Z_count", obj_count, 0);
        chk("Z_ovf", overflow, 1);

        // Two objects sharing X=40 are served in OAM order
        clear_oam();
        oam[12] = 8'd16; oam[13] = 8'd40; oam[14] = 8'h11;
        oam[28] = 8'd16; oam[29] = 8'd40; oam[30] = 8'h22; oam[31] = 8'h40;
        obj_limit = 5'd10;
        run_scan();
        chk("C_count", obj_count, 2);
        drain(40);

        // 8x16 Y-flip row, with an abort at the attribute read
        clear_oam();
        oam[20] = 8'd20; oam[21] = 8'd50; oam[22] = 8'h35; oam[23] = 8'h40;
        v_cnt = 8'd6;
        size16 = 1'b1;
        run_scan();
        h_cnt = 8'd50;
        fetch_en = 1'b1;
        step();
        step();
        fetch_en = 1'b0;
        step();
        chk("abort_valid", fetch_valid, 0);
        repeat (3) step();
        chk("abort_hold", fetch_valid, 0);
        fetch_en = 1'b1;
        wait_valid(n);
        chk("refetch_lat", n, 3);
        chk("D_slot", fetch_slot, 0);
        chk("D_attr", fetch_attr, 8'h40);
        chk("D_saddr", sprite_addr, 11'h1AD);
        fetch_done = 1'b1;
        step();
        fetch_done = 1'b0;
        chk("D_req_after", fetch_req, 0);
        fetch_en = 1'b0;

        // lcd_on drops in the middle of a scan
        setup_row_of_twelve();
        eval_start = 1'b1;
        step();
        eval_start = 1'b0;
        repeat (29) step();
        chk("lcd_mid_busy", eval_busy, 1);
        lcd_on = 1'b0;
        step();
        chk("lcd_busy", eval_busy, 0);
        chk("lcd_count", obj_count, 0);
        chk("lcd_done", eval_done, 0);
        lcd_on = 1'b1;
        repeat (3) step();
        chk("lcd_done_hold", eval_done, 0);
        run_scan();

        // Asynchronous reset while a scan is running
        eval_start = 1'b1;
        step();
        eval_start = 1'b0;
        repeat (10) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", eval_busy, 0);
        chk("arst_count", obj_count, 0);
        chk("arst_addr", oam_rd_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Random OAM contents, lines, limits and sizes
        for (int t = 0; t < 20; t++) begin
            size16 = 1'($urandom_range(0, 1));
            v_cnt = 8'($urandom_range(0, 143));
            obj_limit = 5'($urandom_range(0, 31));
            for (int o = 0; o < 40; o++) begin
                if ($urandom_range(0, 1) == 1)
                    oam[4*o] = 8'(int'(v_cnt) + 16 - int'($urandom_range(0, size16 ? 15 : 7)));
                else
                    oam[4*o] = 8'($urandom_range(0, 255));
                oam[4*o+1] = 8'(8 * $urandom_range(1, 4));
                oam[4*o+2] = 8'($urandom_range(0, 255));
                oam[4*o+3] = 8'($urandom_range(0, 255));
            end
            run_scan();
            model_scan(cnt, ovf);
            hsel = (sel.size() > 0) ? int'(oam[4*sel[$urandom_range(0, sel.size() - 1)] + 1]) : 8;
            drain(hsel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
